// File: rtl/base_nburp.sv
`default_nettype none
// ============================================================================
// Module   : base_nburp
// Brief    : N-entry burp buffer with zero-latency empty bypass and
//            flop-driven ready/almost-full.
// Revision : 1.0
// ============================================================================
module base_nburp #(
  parameter int unsigned width = 1,
  parameter int unsigned depth = 1,
  parameter int unsigned afull = depth
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       din_v,
  output logic                       din_r,
  input  logic [width-1:0]           din_d,
  output logic                       dout_v,
  input  logic                       dout_r,
  output logic [width-1:0]           dout_d,
  output logic                       din_af,
  output logic [$clog2(depth+1)-1:0] cnt
);

  localparam int unsigned     c_CW    = $clog2(depth + 1);
  localparam int unsigned     c_PW    = (depth > 1) ? $clog2(depth) : 1;
  localparam logic [c_CW-1:0] c_FULL  = c_CW'(depth);
  localparam logic [c_CW-1:0] c_AFULL = c_CW'(afull);
  localparam logic [c_PW-1:0] c_LAST  = c_PW'(depth - 1);

  logic [c_CW-1:0]  cnt_q, cnt_d;
  logic [c_PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [c_PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic             din_r_q;
  logic             din_af_q;
  logic [width-1:0] w_head;
  logic             w_empty;
  logic             w_acc_in;
  logic             w_acc_out;
  logic             w_push;
  logic             w_pop;

  assign w_empty   = (cnt_q == '0);
  assign dout_v    = din_v | ~w_empty;
  assign w_acc_in  = din_v & din_r_q;
  assign w_acc_out = dout_v & dout_r;
  // An empty buffer with a ready consumer forwards the beat without storing it.
  assign w_push    = w_acc_in & ~(w_empty & dout_r);
  assign w_pop     = w_acc_out & ~w_empty;

  always_comb begin
    cnt_d    = cnt_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (w_push) begin
      wr_ptr_d = (wr_ptr_q == c_LAST) ? '0 : wr_ptr_q + c_PW'(1);
    end
    if (w_pop) begin
      rd_ptr_d = (rd_ptr_q == c_LAST) ? '0 : rd_ptr_q + c_PW'(1);
    end
    case ({w_push, w_pop})
      2'b10:   cnt_d = cnt_q + c_CW'(1);
      2'b01:   cnt_d = cnt_q - c_CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Ready and almost-full are registered from next-state count so neither
  // depends combinationally on dout_r.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      din_r_q  <= 1'b1;
      din_af_q <= (c_AFULL == '0);
    end else begin
      cnt_q    <= cnt_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      din_r_q  <= (cnt_d != c_FULL);
      din_af_q <= (cnt_d >= c_AFULL);
    end
  end

  generate
    if (depth == 1) begin : g_single
      logic [width-1:0] entry_q;
      always_ff @(posedge clk) begin
        if (w_push) begin
          entry_q <= din_d;
        end
      end
      assign w_head = entry_q;
    end else begin : g_multi
      logic [width-1:0] store_q [depth];
      always_ff @(posedge clk) begin
        if (w_push) begin
          store_q[wr_ptr_q] <= din_d;
        end
      end
      assign w_head = store_q[rd_ptr_q];
    end
  endgenerate

  assign dout_d = w_empty ? din_d : w_head;
  assign din_r  = din_r_q;
  assign din_af = din_af_q;
  assign cnt    = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_base_nburp.sv
`default_nettype none
// ============================================================================
// Module   : tb_base_nburp
// Brief    : Scoreboard bench for base_nburp at depth 4, 3 and 1.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_base_nburp;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // A: depth 4, afull 3
  logic       a_din_v, a_din_r, a_dout_v, a_dout_r, a_din_af;
  logic [7:0] a_din_d, a_dout_d;
  logic [2:0] a_cnt;
  // B: depth 3, afull 2
  logic       b_din_v, b_din_r, b_dout_v, b_dout_r, b_din_af;
  logic [7:0] b_din_d, b_dout_d;
  logic [1:0] b_cnt;
  // C: depth 1, afull 1
  logic       c_din_v, c_din_r, c_dout_v, c_dout_r, c_din_af;
  logic [7:0] c_din_d, c_dout_d;
  logic [0:0] c_cnt;

  base_nburp #(.width(8), .depth(4), .afull(3)) dut_a (
    .clk(clk), .reset(reset), .din_v(a_din_v), .din_r(a_din_r), .din_d(a_din_d),
    .dout_v(a_dout_v), .dout_r(a_dout_r), .dout_d(a_dout_d), .din_af(a_din_af), .cnt(a_cnt));
  base_nburp #(.width(8), .depth(3), .afull(2)) dut_b (
    .clk(clk), .reset(reset), .din_v(b_din_v), .din_r(b_din_r), .din_d(b_din_d),
    .dout_v(b_dout_v), .dout_r(b_dout_r), .dout_d(b_dout_d), .din_af(b_din_af), .cnt(b_cnt));
  base_nburp #(.width(8), .depth(1), .afull(1)) dut_c (
    .clk(clk), .reset(reset), .din_v(c_din_v), .din_r(c_din_r), .din_d(c_din_d),
    .dout_v(c_dout_v), .dout_r(c_dout_r), .dout_d(c_dout_d), .din_af(c_din_af), .cnt(c_cnt));

  logic [7:0] a_q [$];
  logic [7:0] b_q [$];
  logic [7:0] c_q [$];
  int         a_mcnt;
  int         b_mcnt;
  logic       c_full;

  task automatic clear_models();
    a_q.delete(); b_q.delete(); c_q.delete();
    a_mcnt = 0; b_mcnt = 0; c_full = 1'b0;
  endtask

  task automatic idle_inputs();
    a_din_v = 0; a_dout_r = 0; a_din_d = '0;
    b_din_v = 0; b_dout_r = 0; b_din_d = '0;
    c_din_v = 0; c_dout_r = 0; c_din_d = '0;
  endtask

  // Scoreboard bookkeeping for A: returns the expected dout_d, then applies
  // this cycle's accepts to the queue and the occupancy model.
  task automatic a_book(output logic [7:0] exp_d);
    logic in_acc, out_acc;
    exp_d   = (a_mcnt != 0) ? a_q[0] : a_din_d;
    in_acc  = a_din_v && (a_mcnt != 4);
    out_acc = a_dout_r && ((a_mcnt != 0) || a_din_v);
    if (in_acc)  a_q.push_back(a_din_d);
    if (out_acc) void'(a_q.pop_front());
    a_mcnt = a_mcnt + int'(in_acc) - int'(out_acc);
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    a_din_v = 1'b1;
    a_din_d = 8'h5A;
    @(negedge clk);
    n_assert += 6;
    if (a_din_r !== 1'b1)     begin n_fail++; $display("FAIL reset_din_r: got %b expected 1", a_din_r); end
    if (a_din_af !== 1'b0)    begin n_fail++; $display("FAIL reset_din_af: got %b expected 0", a_din_af); end
    if (a_cnt !== 3'd0)       begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", a_cnt); end
    if (a_dout_v !== 1'b1)    begin n_fail++; $display("FAIL reset_bypass_v: got %b expected 1", a_dout_v); end
    if (a_dout_d !== 8'h5A)   begin n_fail++; $display("FAIL reset_bypass_d: got %h expected 5a", a_dout_d); end
    if (b_dout_v !== 1'b0)    begin n_fail++; $display("FAIL reset_idle_v: got %b expected 0", b_dout_v); end
    @(posedge clk); #1;
    reset = 1'b0;
    clear_models();
    idle_inputs();
  endtask

  task automatic test_pass_through();
    logic [7:0] ex;
    a_dout_r = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a_din_v = 1'b1;
      a_din_d = 8'(i + 1);
      @(negedge clk);
      n_assert += 4;
      if (a_dout_v !== 1'b1)      begin n_fail++; $display("FAIL pass_v[%0d]: got %b expected 1", i, a_dout_v); end
      if (a_dout_d !== 8'(i + 1)) begin n_fail++; $display("FAIL pass_d[%0d]: got %h expected %h", i, a_dout_d, 8'(i + 1)); end
      if (a_cnt !== 3'd0)         begin n_fail++; $display("FAIL pass_cnt[%0d]: got %0d expected 0", i, a_cnt); end
      if (a_din_r !== 1'b1)       begin n_fail++; $display("FAIL pass_din_r[%0d]: got %b expected 1", i, a_din_r); end
      a_book(ex);
      @(posedge clk); #1;
    end
    a_din_v = 1'b0;
    a_dout_r = 1'b0;
  endtask

  task automatic test_fill_full();
    logic [7:0] ex;
    int         exp_cnt;
    a_dout_r = 1'b0;
    for (int i = 0; i < 6; i++) begin
      a_din_v = 1'b1;
      a_din_d = 8'(8'h10 + i);
      exp_cnt = (i < 4) ? i : 4;
      @(negedge clk);
      n_assert += 4;
      if (a_cnt !== 3'(exp_cnt))      begin n_fail++; $display("FAIL fill_cnt[%0d]: got %0d expected %0d", i, a_cnt, exp_cnt); end
      if (a_din_r !== (exp_cnt != 4)) begin n_fail++; $display("FAIL fill_din_r[%0d]: got %b expected %b", i, a_din_r, exp_cnt != 4); end
      if (a_din_af !== (exp_cnt >= 3)) begin n_fail++; $display("FAIL fill_din_af[%0d]: got %b expected %b", i, a_din_af, exp_cnt >= 3); end
      if (a_dout_v !== 1'b1)          begin n_fail++; $display("FAIL fill_dout_v[%0d]: got %b expected 1", i, a_dout_v); end
      a_book(ex);
      @(posedge clk); #1;
    end
    n_assert++;
    if (a_q.size() != 4) begin n_fail++; $display("FAIL fill_accepted: got %0d expected 4", a_q.size()); end
  endtask

  task automatic test_drain_refill();
    logic [7:0] ex;
    a_dout_r = 1'b1;
    a_din_v  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      a_din_d = 8'(8'h20 + i);
      @(negedge clk);
      n_assert += 3;
      if (a_cnt !== ((i == 0) ? 3'd4 : 3'd3)) begin n_fail++; $display("FAIL refill_cnt[%0d]: got %0d expected %0d", i, a_cnt, (i == 0) ? 4 : 3); end
      if (a_din_r !== (i != 0))              begin n_fail++; $display("FAIL refill_din_r[%0d]: got %b expected %b", i, a_din_r, i != 0); end
      a_book(ex);
      if (a_dout_d !== ex)                   begin n_fail++; $display("FAIL refill_data[%0d]: got %h expected %h", i, a_dout_d, ex); end
      @(posedge clk); #1;
    end
    a_din_v = 1'b0;
    for (int i = 0; i < 8 && a_mcnt != 0; i++) begin
      @(negedge clk);
      a_book(ex);
      n_assert++;
      if (a_dout_d !== ex) begin n_fail++; $display("FAIL drain_data[%0d]: got %h expected %h", i, a_dout_d, ex); end
      @(posedge clk); #1;
    end
    n_assert++;
    if (a_cnt !== 3'd0) begin n_fail++; $display("FAIL drain_empty: got %0d expected 0", a_cnt); end
    a_dout_r = 1'b0;
  endtask

  task automatic test_reset_midstream();
    logic [7:0] ex;
    a_dout_r = 1'b0;
    for (int i = 0; i < 2; i++) begin
      a_din_v = 1'b1;
      a_din_d = 8'(8'h31 + i);
      @(negedge clk);
      a_book(ex);
      @(posedge clk); #1;
    end
    a_din_v = 1'b0;
    n_assert++;
    if (a_cnt !== 3'd2) begin n_fail++; $display("FAIL mid_pre_cnt: got %0d expected 2", a_cnt); end
    #2 reset = 1'b1;
    #1;
    n_assert += 3;
    if (a_cnt !== 3'd0)    begin n_fail++; $display("FAIL mid_async_cnt: got %0d expected 0", a_cnt); end
    if (a_din_r !== 1'b1)  begin n_fail++; $display("FAIL mid_async_din_r: got %b expected 1", a_din_r); end
    if (a_dout_v !== 1'b0) begin n_fail++; $display("FAIL mid_async_dout_v: got %b expected 0", a_dout_v); end
    #1 reset = 1'b0;
    clear_models();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_assert += 2;
      if (a_dout_v !== 1'b0) begin n_fail++; $display("FAIL mid_stale_v[%0d]: got %b expected 0", i, a_dout_v); end
      if (a_cnt !== 3'd0)    begin n_fail++; $display("FAIL mid_post_cnt[%0d]: got %0d expected 0", i, a_cnt); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_wrap_random();
    logic [7:0] ex;
    logic       in_acc, out_acc;
    int         n_out = 0;
    for (int cyc = 0; cyc < 20000 && n_out < 1000; cyc++) begin
      b_din_v  = ($urandom_range(0, 3) != 0);
      b_dout_r = ($urandom_range(0, 2) != 0);
      b_din_d  = 8'($urandom);
      @(negedge clk);
      n_assert += 4;
      if (b_cnt !== 2'(b_mcnt))                  begin n_fail++; $display("FAIL wrap_cnt[%0d]: got %0d expected %0d", cyc, b_cnt, b_mcnt); end
      if (b_din_r !== (b_mcnt != 3))             begin n_fail++; $display("FAIL wrap_din_r[%0d]: got %b expected %b", cyc, b_din_r, b_mcnt != 3); end
      if (b_din_af !== (b_mcnt >= 2))            begin n_fail++; $display("FAIL wrap_din_af[%0d]: got %b expected %b", cyc, b_din_af, b_mcnt >= 2); end
      if (b_dout_v !== ((b_mcnt != 0) || b_din_v)) begin n_fail++; $display("FAIL wrap_dout_v[%0d]: got %b", cyc, b_dout_v); end
      ex      = (b_mcnt != 0) ? b_q[0] : b_din_d;
      in_acc  = b_din_v && (b_mcnt != 3);
      out_acc = b_dout_r && ((b_mcnt != 0) || b_din_v);
      if ((b_mcnt != 0) || b_din_v) begin
        n_assert++;
        if (b_dout_d !== ex) begin n_fail++; $display("FAIL wrap_data[%0d]: got %h expected %h", cyc, b_dout_d, ex); end
      end
      if (in_acc)  b_q.push_back(b_din_d);
      if (out_acc) begin void'(b_q.pop_front()); n_out++; end
      b_mcnt = b_mcnt + int'(in_acc) - int'(out_acc);
      @(posedge clk); #1;
    end
    n_assert++;
    if (n_out < 1000) begin n_fail++; $display("FAIL wrap_timeout: got %0d beats expected 1000", n_out); end
    b_din_v = 1'b0;
    b_dout_r = 1'b0;
  endtask

  task automatic test_depth1_equiv();
    logic [7:0] ex;
    logic       in_acc, out_acc;
    for (int cyc = 0; cyc < 400; cyc++) begin
      c_din_v  = 1'($urandom_range(0, 1));
      c_dout_r = 1'($urandom_range(0, 1));
      c_din_d  = 8'($urandom);
      @(negedge clk);
      n_assert += 3;
      if (c_din_r !== ~c_full)              begin n_fail++; $display("FAIL d1_din_r[%0d]: got %b expected %b", cyc, c_din_r, ~c_full); end
      if (c_dout_v !== (c_full | c_din_v))  begin n_fail++; $display("FAIL d1_dout_v[%0d]: got %b expected %b", cyc, c_dout_v, c_full | c_din_v); end
      if (c_cnt !== c_full)                 begin n_fail++; $display("FAIL d1_cnt[%0d]: got %0d expected %0d", cyc, c_cnt, c_full); end
      ex      = c_full ? c_q[0] : c_din_d;
      in_acc  = c_din_v & ~c_full;
      out_acc = c_dout_r & (c_full | c_din_v);
      if (c_full | c_din_v) begin
        n_assert++;
        if (c_dout_d !== ex) begin n_fail++; $display("FAIL d1_data[%0d]: got %h expected %h", cyc, c_dout_d, ex); end
      end
      if (in_acc)  c_q.push_back(c_din_d);
      if (out_acc) void'(c_q.pop_front());
      c_full = c_full ? ~c_dout_r : (c_din_v & ~c_dout_r);
      @(posedge clk); #1;
    end
    c_din_v = 1'b0;
    c_dout_r = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_models();
    idle_inputs();
    test_reset();
    test_pass_through();
    test_fill_full();
    test_drain_refill();
    test_reset_midstream();
    test_wrap_random();
    test_depth1_equiv();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/base_nburp.md
BASE_NBURP -- requirements
Module: base_nburp

Interface
REQ-001 SHALL have parameter width, default 1, meaning data bits per beat (1..1024).
REQ-002 SHALL have parameter depth, default 1, meaning burp entries (1..32, any integer, not limited to powers of two).
REQ-003 SHALL have parameter afull, default depth, meaning the occupancy threshold for din_af (0..depth).
REQ-004 SHALL have port: clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port: din_v  input  1  upstream beat valid.
REQ-007 SHALL have port: din_r  output  1  upstream ready; driven only from flops.
REQ-008 SHALL have port: din_d  input  width  upstream data.
REQ-009 SHALL have port: dout_v  output  1  downstream beat valid.
REQ-010 SHALL have port: dout_r  input  1  downstream ready.
REQ-011 SHALL have port: dout_d  output  width  downstream data.
REQ-012 SHALL have port: din_af  output  1  almost-full: occupancy >= afull; driven only from flops.
REQ-013 SHALL have port: cnt  output  $clog2(depth+1)  current occupancy.

Function
REQ-014 SHALL define accept-in = din_v & din_r and accept-out = dout_v & dout_r.
REQ-015 SHALL hold beats in a circular store of depth entries, with rd_ptr, wr_ptr and cnt registers.
REQ-016 SHALL drive din_r = (cnt != depth), so no combinational path exists from dout_r to din_r.
REQ-017 SHALL drive dout_v = din_v | (cnt != 0) when empty bypass is possible, i.e. dout_v = (cnt != 0) | din_v.
REQ-018 SHALL drive dout_d = store[rd_ptr] when cnt != 0, else din_d (zero-latency bypass).
REQ-019 SHALL, with cnt == 0, din_v = 1 and dout_r = 1, pass the beat straight through; no write occurs and cnt is unchanged.
REQ-020 SHALL, with cnt == 0, din_v = 1 and dout_r = 0, write din_d to store[wr_ptr] and set cnt to 1 next cycle.
REQ-021 SHALL, with cnt != 0, write every accepted input to the tail and pop the head on every accepted output.
REQ-022 SHALL leave cnt unchanged on a simultaneous push and pop with 0 < cnt < depth.
REQ-023 SHALL, at cnt == depth, keep din_r = 0 and ignore din_v.
REQ-024 SHALL, on a pop while full, set cnt to depth-1 and raise din_r on the following cycle; no same-cycle refill occurs.
REQ-025 SHALL wrap rd_ptr and wr_ptr from depth-1 to 0, including when depth is not a power of two.
REQ-026 SHALL deliver beats in strict arrival order, never duplicating or dropping an accepted beat.
REQ-027 SHALL keep dout_v asserted and dout_d stable while dout_r = 0 and cnt != 0.
REQ-028 SHALL register din_af so that it equals (cnt >= afull) for the current cnt; afull = 0 holds din_af at 1.
REQ-029 SHALL behave, with depth = 1, cycle-identically to the single-entry burp control, extended with the data path.

Reset
REQ-030 SHALL, while reset = 1, asynchronously force cnt = 0, rd_ptr = 0 and wr_ptr = 0.
REQ-031 SHALL, while reset = 1, drive din_r = 1 and din_af = (afull == 0).
REQ-032 SHALL, while reset = 1, drive dout_v = din_v and dout_d = din_d (bypass).
REQ-033 SHALL NOT reset the storage array.
REQ-034 SHALL discard all buffered beats on reset asserted mid-operation, with no spurious dout_v from stale entries after release.

Verification
REQ-035 SHALL cover pass-through: depth=4, dout_r=1, din_v streaming 0x1,0x2,0x3 -> dout_d 0x1,0x2,0x3 in the same cycles, with cnt = 0 throughout.
REQ-036 SHALL cover the fill-to-full stall: depth=4, dout_r=0, 6 beats offered -> 4 accepted, din_r=0 from the cycle cnt=4, din_af=1 with afull=3 once cnt=3.
REQ-037 SHALL cover drain with refill: from full, dout_r=1 with din_v=1 -> one pop at cnt=4, din_r rises the next cycle, then cnt holds at 3 with order preserved.
REQ-038 SHALL cover non-power-of-two wrap: depth=3, randomised din_v/dout_r over 1000 beats -> scoreboard matches exactly, pointers wrap 2->0, cnt never exceeds 3.
REQ-039 SHALL cover reset mid-stream: cnt=2, reset pulsed asynchronously between edges -> cnt=0 and din_r=1 immediately, dout_v=0 while din_v=0 after release.
REQ-040 SHALL cover the depth=1 equivalence check: randomised din_v/dout_r -> din_r and dout_v match the single-entry burp control cycle for cycle.
